// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N-to-1 valid/ready stream multiplexer with a single registered output
//   stage. MODE 0 forwards the channel chosen by sel. MODE 1 arbitrates
//   round-robin among the valid channels.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    N*WIDTH payloads, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   sel        channel select (MODE 0 only)
//   out_data   registered payload
//   out_valid  output register holds data
//   out_ready  downstream ready
//   out_chan   registered source channel index of out_data
module stream_mux_rr #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int MODE  = 0,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_chan
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] grant_idx;
    logic          grant;
    logic          open;
    logic          take;

    // Output register can accept a word when empty or draining this cycle.
    assign open = !out_valid || out_ready;
    assign take = grant && open && !rst;

    always_comb begin
        int sel_i;
        int ptr_i;
        int idx;
        grant     = 1'b0;
        grant_idx = '0;
        sel_i     = int'(sel);
        ptr_i     = int'(ptr);
        idx       = 0;
        if (MODE == 0) begin
            // sel may exceed N-1 when N is not a power of two; that is
            // simply "no grant".
            if (sel_i < N) begin
                if (in_valid[sel_i]) begin
                    grant     = 1'b1;
                    grant_idx = sel;
                end
            end
        end else begin
            // Rotating-priority search starting at ptr; first hit wins.
            for (int k = 0; k < N; k++) begin
                idx = ptr_i + k;
                if (idx >= N) idx = idx - N;
                if (!grant && in_valid[idx]) begin
                    grant     = 1'b1;
                    grant_idx = idx[SW-1:0];
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = take && (int'(grant_idx) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
                out_chan  <= grant_idx;
                if (MODE == 1) begin
                    if (int'(grant_idx) == N - 1) ptr <= '0;
                    else                         ptr <= grant_idx + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                // Drained with no refill: data and channel are held.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr: three instances cover fixed select
// (N=8), round-robin (N=8) and fixed select with a non-power-of-two
// channel count (N=6, WIDTH=16).
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // MODE 0, N=8, WIDTH=32
    logic [255:0] a_data;
    logic [7:0]   a_valid, a_ready;
    logic [2:0]   a_sel, a_chan;
    logic [31:0]  a_out;
    logic         a_ovalid, a_oready;

    // MODE 1, N=8, WIDTH=32
    logic [255:0] b_data;
    logic [7:0]   b_valid, b_ready;
    logic [2:0]   b_sel, b_chan;
    logic [31:0]  b_out;
    logic         b_ovalid, b_oready;

    // MODE 0, N=6, WIDTH=16
    logic [95:0]  c_data;
    logic [5:0]   c_valid, c_ready;
    logic [2:0]   c_sel, c_chan;
    logic [15:0]  c_out;
    logic         c_ovalid, c_oready;

    stream_mux_rr #(.WIDTH(32), .N(8), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .sel(a_sel), .out_data(a_out),
        .out_valid(a_ovalid), .out_ready(a_oready), .out_chan(a_chan));

    stream_mux_rr #(.WIDTH(32), .N(8), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .sel(b_sel), .out_data(b_out),
        .out_valid(b_ovalid), .out_ready(b_oready), .out_chan(b_chan));

    stream_mux_rr #(.WIDTH(16), .N(6), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid),
        .in_ready(c_ready), .sel(c_sel), .out_data(c_out),
        .out_valid(c_ovalid), .out_ready(c_oready), .out_chan(c_chan));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq [3];
        rst = 1'b1;
        a_data = '0; a_valid = '0; a_sel = '0; a_oready = 1'b1;
        b_data = '0; b_valid = '0; b_sel = '0; b_oready = 1'b1;
        c_data = '0; c_valid = '0; c_sel = '0; c_oready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_data[i*32 +: 32] = 32'h1000_0000 + i;
            b_data[i*32 +: 32] = 32'hA0 + i;
        end
        for (int i = 0; i < 6; i++) c_data[i*16 +: 16] = 16'h0600 + 16'(i);
        a_data[5*32 +: 32] = 32'hDEADBEEF;

        // Reset: everything valid, yet no ready and cleared outputs.
        tick(); tick();
        a_valid = 8'hFF; a_sel = 3'd5; b_valid = 8'hFF; c_valid = 6'h3F; c_sel = 3'd1;
        #1;
        chk("rst_a_ready", a_ready, 8'h00);
        chk("rst_b_ready", b_ready, 8'h00);
        chk("rst_c_ready", c_ready, 6'h00);
        tick();
        chk("rst_a_ovalid", a_ovalid, 0);
        chk("rst_a_data", a_out, 0);
        chk("rst_a_chan", a_chan, 0);
        chk("rst_b_ovalid", b_ovalid, 0);
        a_valid = '0; b_valid = '0; c_valid = '0;
        rst = 1'b0;
        tick();

        // Fixed select of channel 5.
        a_sel = 3'd5; a_valid = 8'h20; a_oready = 1'b1;
        #1;
        chk("sel5_ready", a_ready, 8'h20);
        tick();
        chk("sel5_ovalid", a_ovalid, 1);
        chk("sel5_data", a_out, 32'hDEADBEEF);
        chk("sel5_chan", a_chan, 5);
        a_valid = '0;
        #1;
        chk("idle_ready", a_ready, 8'h00);
        tick();
        chk("drain_ovalid", a_ovalid, 0);
        chk("drain_data_held", a_out, 32'hDEADBEEF);
        chk("drain_chan_held", a_chan, 5);

        // Backpressure: hold ch1 word while ch2 waits, then no bubble.
        a_sel = 3'd1; a_valid = 8'h02;
        tick();
        chk("bp_load_data", a_out, 32'h1000_0001);
        a_sel = 3'd2; a_valid = 8'h04; a_oready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", a_ready, 8'h00);
            tick();
            chk("bp_ovalid", a_ovalid, 1);
            chk("bp_data", a_out, 32'h1000_0001);
            chk("bp_chan", a_chan, 1);
        end
        a_oready = 1'b1;
        #1;
        chk("bp_release_ready", a_ready, 8'h04);
        tick();
        chk("bp_next_ovalid", a_ovalid, 1);
        chk("bp_next_data", a_out, 32'h1000_0002);
        chk("bp_next_chan", a_chan, 2);
        a_valid = '0;
        tick();

        // N=6: out-of-range selects never grant.
        c_valid = 6'h3F; c_oready = 1'b1;
        for (int s = 6; s < 8; s++) begin
            c_sel = 3'(s);
            #1;
            chk("oor_ready", c_ready, 6'h00);
            tick();
            chk("oor_ovalid", c_ovalid, 0);
        end
        c_sel = 3'd3;
        #1;
        chk("n6_sel3_ready", c_ready, 6'h08);
        tick();
        chk("n6_sel3_data", c_out, 16'h0603);
        chk("n6_sel3_chan", c_chan, 3);
        c_valid = '0;
        tick();

        // Round-robin with all channels valid: 0..7 then wrap to 0.
        b_valid = 8'hFF; b_oready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("rr_ready", b_ready, 8'h01 << (k % 8));
            tick();
            chk("rr_chan", b_chan, k % 8);
            chk("rr_data", b_out, 32'hA0 + (k % 8));
        end
        // ptr is now 1; grant ch1 alone to move it to 2.
        b_valid = 8'h02;
        tick();
        chk("rr_ptr2_chan", b_chan, 1);

        // Sparse: from ptr=2 with ch1/ch7 valid -> 7, 1, 7.
        b_valid = 8'b1000_0010;
        seq[0] = 7; seq[1] = 1; seq[2] = 7;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("sparse_ready", b_ready, 8'h01 << seq[k]);
            tick();
            chk("sparse_chan", b_chan, seq[k]);
        end

        // Reset mid-stream with a held word; restart search at ch0.
        b_valid = 8'h08;
        tick();
        chk("pre_rst_chan", b_chan, 3);
        b_oready = 1'b0;
        b_valid = 8'hFF;
        rst = 1'b1;
        #1;
        chk("midrst_ready", b_ready, 8'h00);
        tick();
        chk("midrst_ovalid", b_ovalid, 0);
        chk("midrst_data", b_out, 0);
        chk("midrst_chan", b_chan, 0);
        rst = 1'b0;
        b_oready = 1'b1;
        #1;
        chk("post_rst_ready", b_ready, 8'h01);
        tick();
        chk("post_rst_chan", b_chan, 0);
        chk("post_rst_data", b_out, 32'hA0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width per channel in bits (1..64).
REQ-002 Parameter N, default 8, SHALL set the input channel count (2..16; need not be a power of two).
REQ-003 Parameter MODE, default 0, SHALL select the mode: 0 = fixed select via sel, 1 = round-robin among valid channels.
REQ-004 Localparam SW = max(1, ceil(log2(N))) SHALL set the select/channel-index width.
REQ-005 clk  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 in_data  input  N*WIDTH  SHALL carry the channel payloads; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  SHALL carry per-channel valid flags.
REQ-009 in_ready  output  N  SHALL carry per-channel ready flags; it is combinational and one-hot or zero.
REQ-010 sel  input  SW  SHALL be the channel select; it is used in MODE 0 and ignored in MODE 1.
REQ-011 out_data  output  WIDTH  SHALL be the registered payload.
REQ-012 out_valid  output  1  SHALL flag that the output register holds data.
REQ-013 out_ready  input  1  SHALL be the downstream ready.
REQ-014 out_chan  output  SW  SHALL be the registered index of the source channel of out_data.

Function
REQ-015 A channel transfer SHALL occur on a cycle where in_valid[i] and in_ready[i] are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-016 The output register SHALL be "open" when out_valid=0, or when out_valid=1 and out_ready=1 (same-cycle drain and refill, full throughput).
REQ-017 Grant in MODE 0: the granted channel SHALL be g=sel when sel<N and in_valid[sel]=1; otherwise no grant.
REQ-018 Grant in MODE 1: the granted channel SHALL be the first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1; if no channel is valid there is no grant.
REQ-019 in_ready[g] SHALL be 1 only when a grant exists, the output register is open and rst=0; all other in_ready bits SHALL be 0.
REQ-020 On a channel transfer, out_data<=in_data[g], out_chan<=g and out_valid<=1 SHALL load on the next edge, giving latency exactly 1 cycle from input to output.
REQ-021 When the output transfers and no channel transfers in the same cycle, out_valid SHALL go to 0, with out_data and out_chan held.
REQ-022 When out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL be held and in_ready SHALL be all 0 (backpressure).
REQ-023 MODE 1 pointer: on each channel transfer, ptr SHALL update to (g+1) mod N, wrapping from N-1 to 0; otherwise ptr SHALL be held.
REQ-024 Out-of-range select in MODE 0 (sel>=N): no transfer SHALL occur and in_ready SHALL be 0; this is not an error.
REQ-025 A change of sel while out_valid=1 SHALL NOT affect the registered out_data or out_chan.
REQ-026 The design SHALL contain no combinational path from in_data or in_valid to out_data, out_valid or out_chan; paths to in_ready are permitted.

Reset
REQ-027 While rst=1 at a rising edge, the following SHALL be set: out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-028 While rst=1, in_ready SHALL be all 0, so no channel transfer occurs.
REQ-029 When rst is asserted mid-operation, any held output word SHALL be discarded and the upstream SHALL see no handshake that cycle.

Verification
REQ-030 Scenario (MODE 0, N=8, WIDTH=32): sel=5, in_valid=8'h20, in_data ch5=32'hDEADBEEF, out_ready=1 -> in_ready=8'h20; the next cycle gives out_valid=1, out_data=32'hDEADBEEF, out_chan=5.
REQ-031 Scenario (backpressure): out_valid=1, out_ready=0 for 3 cycles with ch2 valid -> in_ready=0 and out_data stable; on the cycle out_ready=1, in_ready[2]=1, and the ch2 word appears the next cycle with no bubble.
REQ-032 Scenario (MODE 1, round-robin): all 8 valid, out_ready=1 constantly -> out_chan sequence 0,1,2,...,7,0; ptr wraps from 7 to 0.
REQ-033 Scenario (MODE 1, sparse): in_valid=8'b1000_0010 with ptr=2 -> grant ch7, then ch1, then ch7; only valid channels are ever granted.
REQ-034 Scenario (MODE 0, N=6): sel=6 or sel=7 with all valid -> in_ready=0 and out_valid stays 0.
REQ-035 Scenario (reset mid-stream): rst=1 while out_valid=1 -> the next cycle gives out_valid=0, out_data=0, out_chan=0, in_ready=0; after rst deasserts in MODE 1, the first grant starts search at ch0.
